// File: rtl/lt_sched.sv
// lt_sched: round-robin master LT_ADDR scheduler with per-LT ACL SEQN/ARQ tracking
module lt_sched (
  input  logic       clk_6M,
  input  logic       rst,
  input  logic       enable,
  input  logic       ms_tslot_p,
  input  logic [7:0] active_mask,
  input  logic [7:0] txpend,
  input  logic [7:0] flow_go,
  input  logic       tx_done_p,
  input  logic       ckheader_endp,
  input  logic       dec_hecgood,
  input  logic       lt_addressed,
  input  logic       rx_arqn,
  input  logic       rx_slot_end_p,
  output logic [2:0] sched_lt_addr,
  output logic       sched_data,
  output logic       tx_req_p,
  output logic [7:0] txaclSEQN,
  output logic       ack_p,
  output logic [2:0] ack_lt,
  output logic       slot_miss_p,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, TX, RX, EVAL} state_t;
  state_t r_state, w_next;
  logic [2:0] r_lt, r_last, r_ack_lt, w_sel_lt, w_data_lt, w_poll_lt;
  logic       r_data, r_tx_req, r_ack, r_miss, w_has_data, w_start, w_ack;
  logic [7:0] r_seqn;
  logic [3:0] w_idx;
  // scan LTs from r_last+1 downwards in reverse so the nearest candidate in RR order wins
  always_comb begin
    w_data_lt = '0;
    w_poll_lt = '0;
    w_has_data = 1'b0;
    w_idx = '0;
    for (int k = 7; k >= 1; k--) begin
      w_idx = {1'b0, r_last} + 4'(k);
      w_idx = (w_idx > 4'd7) ? w_idx - 4'd7 : w_idx;
      if (active_mask[w_idx[2:0]]) begin
        w_poll_lt = w_idx[2:0];
        if (txpend[w_idx[2:0]] & flow_go[w_idx[2:0]]) begin
          w_data_lt = w_idx[2:0];
          w_has_data = 1'b1;
        end
      end
    end
    w_sel_lt = w_has_data ? w_data_lt : w_poll_lt;
  end
  assign w_start = (r_state == IDLE) & enable & ms_tslot_p & (|active_mask[7:1]);
  assign w_ack   = (r_state == EVAL) & enable & r_data & dec_hecgood & lt_addressed & rx_arqn;
  // state register
  always_ff @(posedge clk_6M)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  // next state; header check beats RX timeout, enable low always returns to IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_start ? TX : IDLE;
      TX:      w_next = tx_done_p ? RX : TX;
      RX:      w_next = ckheader_endp ? EVAL : (rx_slot_end_p ? IDLE : RX);
      default: w_next = IDLE;
    endcase
    if (!enable) w_next = IDLE;
  end
  // selection latch, single-cycle pulses and per-LT SEQN toggling on acknowledged data
  always_ff @(posedge clk_6M)
    if (rst) begin
      r_lt     <= '0;
      r_data   <= 1'b0;
      r_last   <= 3'd7;
      r_seqn   <= 8'hff;
      r_tx_req <= 1'b0;
      r_ack    <= 1'b0;
      r_ack_lt <= '0;
      r_miss   <= 1'b0;
    end else begin
      r_tx_req <= w_start;
      r_ack    <= w_ack;
      r_miss   <= ms_tslot_p & (r_state != IDLE);
      if (w_start) begin
        r_lt   <= w_sel_lt;
        r_data <= w_has_data;
        r_last <= w_sel_lt;
      end
      if (w_ack) begin
        r_ack_lt     <= r_lt;
        r_seqn[r_lt] <= ~r_seqn[r_lt];
      end
    end
  assign sched_lt_addr = r_lt;
  assign sched_data    = r_data;
  assign tx_req_p      = r_tx_req;
  assign txaclSEQN     = r_seqn;
  assign ack_p         = r_ack;
  assign ack_lt        = r_ack_lt;
  assign slot_miss_p   = r_miss;
  assign busy          = (r_state != IDLE);
endmodule

// File: tb/tb_lt_sched.sv
// tb_lt_sched: scenario tasks plus randomized traffic checked against a slot-level scheduler model
module tb_lt_sched;
  logic       clk_6M = 1'b0;
  logic       rst, enable, ms_tslot_p, tx_done_p, ckheader_endp;
  logic       dec_hecgood, lt_addressed, rx_arqn, rx_slot_end_p;
  logic [7:0] active_mask, txpend, flow_go;
  logic [2:0] sched_lt_addr, ack_lt;
  logic       sched_data, tx_req_p, ack_p, slot_miss_p, busy;
  logic [7:0] txaclSEQN;
  int         n_chk = 0, n_pass = 0;
  int         m_last;
  logic [7:0] m_seqn;
  int         lt;
  bit         d;

  lt_sched dut (
    .clk_6M(clk_6M), .rst(rst), .enable(enable), .ms_tslot_p(ms_tslot_p),
    .active_mask(active_mask), .txpend(txpend), .flow_go(flow_go),
    .tx_done_p(tx_done_p), .ckheader_endp(ckheader_endp), .dec_hecgood(dec_hecgood),
    .lt_addressed(lt_addressed), .rx_arqn(rx_arqn), .rx_slot_end_p(rx_slot_end_p),
    .sched_lt_addr(sched_lt_addr), .sched_data(sched_data), .tx_req_p(tx_req_p),
    .txaclSEQN(txaclSEQN), .ack_p(ack_p), .ack_lt(ack_lt),
    .slot_miss_p(slot_miss_p), .busy(busy)
  );

  always #5 clk_6M = ~clk_6M;

  function automatic void pick(input logic [7:0] m, p, g, input int last, output int sel, output bit dat);
    sel = 0;
    dat = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      int i = (last + k - 1) % 7 + 1;
      if (m[i] && p[i] && g[i]) begin sel = i; dat = 1'b1; return; end
    end
    for (int k = 1; k <= 7; k++) begin
      int i = (last + k - 1) % 7 + 1;
      if (m[i]) begin sel = i; return; end
    end
  endfunction

  task automatic do_reset();
    @(negedge clk_6M);
    rst = 1; enable = 1; ms_tslot_p = 0; tx_done_p = 0; ckheader_endp = 0; rx_slot_end_p = 0;
    dec_hecgood = 0; lt_addressed = 0; rx_arqn = 0; active_mask = 0; txpend = 0; flow_go = 0;
    repeat (2) @(negedge clk_6M);
    rst = 0;
    m_last = 7;
    m_seqn = 8'hff;
  endtask

  task automatic start_slot();
    ms_tslot_p = 1;
    @(negedge clk_6M);
    ms_tslot_p = 0;
  endtask

  task automatic finish_slot(input bit to);
    tx_done_p = 1;
    @(negedge clk_6M);
    tx_done_p = 0;
    if (to) rx_slot_end_p = 1; else ckheader_endp = 1;
    @(negedge clk_6M);
    rx_slot_end_p = 0;
    ckheader_endp = 0;
    if (!to) @(negedge clk_6M);
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (sched_lt_addr !== 3'd0) $display("FAIL reset_lt: got %0d want 0", sched_lt_addr); else n_pass++;
    n_chk++; if (sched_data !== 1'b0) $display("FAIL reset_data: got %b want 0", sched_data); else n_pass++;
    n_chk++; if (txaclSEQN !== 8'hff) $display("FAIL reset_seqn: got %h want ff", txaclSEQN); else n_pass++;
    n_chk++; if ({busy, tx_req_p, ack_p, slot_miss_p} !== 4'b0) $display("FAIL reset_pulses: got %b want 0000", {busy, tx_req_p, ack_p, slot_miss_p}); else n_pass++;
    n_chk++; if (ack_lt !== 3'd0) $display("FAIL reset_acklt: got %0d want 0", ack_lt); else n_pass++;
  endtask

  task automatic test_poll_rr();
    active_mask = 8'h0E; txpend = 8'h00; flow_go = 8'hFF;
    for (int n = 0; n < 4; n++) begin
      start_slot();
      pick(active_mask, txpend, flow_go, m_last, lt, d);
      m_last = lt;
      n_chk++; if (tx_req_p !== 1'b1) $display("FAIL poll_txreq: got %b want 1", tx_req_p); else n_pass++;
      n_chk++; if ({sched_lt_addr, sched_data} !== {3'(lt), d}) $display("FAIL poll_sel: got %0d/%b want %0d/%b", sched_lt_addr, sched_data, lt, d); else n_pass++;
      if (n == 0) begin
        @(negedge clk_6M);
        n_chk++; if (tx_req_p !== 1'b0 || busy !== 1'b1) $display("FAIL txreq_width: got %b/%b want 0/1", tx_req_p, busy); else n_pass++;
      end
      finish_slot(1);
    end
    enable = 0;
    start_slot();
    n_chk++; if ({tx_req_p, busy} !== 2'b00) $display("FAIL disabled_slot: got %b want 00", {tx_req_p, busy}); else n_pass++;
    enable = 1; active_mask = 8'h01; txpend = 8'h01;
    start_slot();
    n_chk++; if ({tx_req_p, busy} !== 2'b00) $display("FAIL no_active_slot: got %b want 00", {tx_req_p, busy}); else n_pass++;
  endtask

  task automatic test_wrap_data();
    active_mask = 8'h40; txpend = 8'h00; flow_go = 8'hFF;
    start_slot();
    pick(active_mask, txpend, flow_go, m_last, lt, d);
    m_last = lt;
    n_chk++; if (sched_lt_addr !== 3'(lt)) $display("FAIL wrap_pre: got %0d want %0d", sched_lt_addr, lt); else n_pass++;
    finish_slot(1);
    active_mask = 8'hFE; txpend = 8'h20;
    start_slot();
    pick(active_mask, txpend, flow_go, m_last, lt, d);
    m_last = lt;
    n_chk++; if ({sched_lt_addr, sched_data} !== {3'(lt), d}) $display("FAIL wrap_sel: got %0d/%b want %0d/%b", sched_lt_addr, sched_data, lt, d); else n_pass++;
    finish_slot(1);
  endtask

  task automatic test_ack();
    do_reset();
    active_mask = 8'h08; txpend = 8'h08; flow_go = 8'hFF;
    dec_hecgood = 1; lt_addressed = 1; rx_arqn = 1;
    start_slot();
    pick(active_mask, txpend, flow_go, m_last, lt, d);
    m_last = lt;
    n_chk++; if ({sched_lt_addr, sched_data} !== {3'(lt), d}) $display("FAIL ack_sel: got %0d/%b want %0d/%b", sched_lt_addr, sched_data, lt, d); else n_pass++;
    finish_slot(0);
    m_seqn[lt] = ~m_seqn[lt];
    n_chk++; if ({ack_p, ack_lt} !== {1'b1, 3'(lt)}) $display("FAIL ack_pulse: got %b/%0d want 1/%0d", ack_p, ack_lt, lt); else n_pass++;
    n_chk++; if (txaclSEQN !== m_seqn) $display("FAIL ack_seqn: got %h want %h", txaclSEQN, m_seqn); else n_pass++;
    @(negedge clk_6M);
    n_chk++; if (ack_p !== 1'b0) $display("FAIL ack_width: got %b want 0", ack_p); else n_pass++;
    rx_arqn = 0;
    start_slot();
    m_last = 3;
    finish_slot(0);
    n_chk++; if ({ack_p, txaclSEQN} !== {1'b0, m_seqn}) $display("FAIL nak: got %b/%h want 0/%h", ack_p, txaclSEQN, m_seqn); else n_pass++;
    rx_arqn = 1; txpend = 8'h00;
    start_slot();
    finish_slot(0);
    n_chk++; if ({ack_p, txaclSEQN} !== {1'b0, m_seqn}) $display("FAIL poll_noack: got %b/%h want 0/%h", ack_p, txaclSEQN, m_seqn); else n_pass++;
  endtask

  task automatic test_flow_stop();
    active_mask = 8'h06; txpend = 8'h04; flow_go = 8'hFB;
    dec_hecgood = 1; lt_addressed = 1; rx_arqn = 1;
    for (int n = 0; n < 4; n++) begin
      start_slot();
      pick(active_mask, txpend, flow_go, m_last, lt, d);
      m_last = lt;
      n_chk++; if ({sched_lt_addr, sched_data} !== {3'(lt), d}) $display("FAIL flow_sel: got %0d/%b want %0d/%b", sched_lt_addr, sched_data, lt, d); else n_pass++;
      finish_slot(0);
      n_chk++; if ({ack_p, txaclSEQN} !== {1'b0, m_seqn}) $display("FAIL flow_ack: got %b/%h want 0/%h", ack_p, txaclSEQN, m_seqn); else n_pass++;
    end
  endtask

  task automatic test_slot_miss();
    active_mask = 8'h02; txpend = 8'h02; flow_go = 8'hFF;
    start_slot();
    pick(active_mask, txpend, flow_go, m_last, lt, d);
    m_last = lt;
    tx_done_p = 1;
    @(negedge clk_6M);
    tx_done_p = 0;
    start_slot();
    n_chk++; if ({slot_miss_p, busy, tx_req_p} !== 3'b110) $display("FAIL miss_pulse: got %b want 110", {slot_miss_p, busy, tx_req_p}); else n_pass++;
    @(negedge clk_6M);
    n_chk++; if ({slot_miss_p, busy} !== 2'b01) $display("FAIL miss_width: got %b want 01", {slot_miss_p, busy}); else n_pass++;
    ckheader_endp = 1; rx_slot_end_p = 1;
    @(negedge clk_6M);
    ckheader_endp = 0; rx_slot_end_p = 0;
    n_chk++; if (busy !== 1'b1) $display("FAIL coincide_eval: got busy %b want 1", busy); else n_pass++;
    @(negedge clk_6M);
    m_seqn[lt] = ~m_seqn[lt];
    n_chk++; if ({ack_p, txaclSEQN} !== {1'b1, m_seqn}) $display("FAIL coincide_ack: got %b/%h want 1/%h", ack_p, txaclSEQN, m_seqn); else n_pass++;
  endtask

  task automatic test_enable_drop();
    active_mask = 8'h02; txpend = 8'h02; flow_go = 8'hFF;
    start_slot();
    pick(active_mask, txpend, flow_go, m_last, lt, d);
    m_last = lt;
    enable = 0;
    @(negedge clk_6M);
    n_chk++; if ({busy, tx_req_p, txaclSEQN} !== {2'b00, m_seqn}) $display("FAIL en_drop: got %b/%h want 00/%h", {busy, tx_req_p}, txaclSEQN, m_seqn); else n_pass++;
    enable = 1; active_mask = 8'h06; txpend = 8'h00;
    start_slot();
    pick(active_mask, txpend, flow_go, m_last, lt, d);
    m_last = lt;
    n_chk++; if (sched_lt_addr !== 3'(lt)) $display("FAIL en_last_kept: got %0d want %0d", sched_lt_addr, lt); else n_pass++;
    finish_slot(1);
    active_mask = 8'h02; txpend = 8'h02;
    start_slot();
    m_last = 1;
    tx_done_p = 1;
    @(negedge clk_6M);
    tx_done_p = 0; ckheader_endp = 1;
    @(negedge clk_6M);
    ckheader_endp = 0; enable = 0;
    @(negedge clk_6M);
    n_chk++; if ({ack_p, busy, txaclSEQN} !== {2'b00, m_seqn}) $display("FAIL en_eval: got %b/%h want 00/%h", {ack_p, busy}, txaclSEQN, m_seqn); else n_pass++;
    enable = 1;
  endtask

  task automatic test_rst_mid();
    active_mask = 8'h02; txpend = 8'h02; flow_go = 8'hFF;
    start_slot();
    tx_done_p = 1;
    @(negedge clk_6M);
    tx_done_p = 0; ckheader_endp = 1; rst = 1;
    @(negedge clk_6M);
    ckheader_endp = 0; rst = 0;
    m_last = 7; m_seqn = 8'hff;
    n_chk++; if ({busy, sched_data, sched_lt_addr, txaclSEQN} !== {2'b00, 3'd0, 8'hff}) $display("FAIL rst_mid: got %b/%0d/%h want 00/0/ff", {busy, sched_data}, sched_lt_addr, txaclSEQN); else n_pass++;
    @(negedge clk_6M);
    n_chk++; if ({ack_p, txaclSEQN} !== {1'b0, 8'hff}) $display("FAIL rst_mid_ack: got %b/%h want 0/ff", ack_p, txaclSEQN); else n_pass++;
  endtask

  task automatic test_random();
    bit to, exp_ack;
    for (int n = 0; n < 60; n++) begin
      active_mask = 8'($urandom); txpend = 8'($urandom); flow_go = 8'($urandom);
      dec_hecgood = $urandom_range(0, 3) != 0;
      lt_addressed = $urandom_range(0, 3) != 0;
      rx_arqn = $urandom_range(0, 2) != 0;
      to = $urandom_range(0, 4) == 0;
      start_slot();
      if (active_mask[7:1] == 7'd0) begin
        n_chk++; if ({tx_req_p, busy} !== 2'b00) $display("FAIL rnd_idle: got %b want 00", {tx_req_p, busy}); else n_pass++;
      end else begin
        pick(active_mask, txpend, flow_go, m_last, lt, d);
        m_last = lt;
        n_chk++; if ({tx_req_p, sched_lt_addr, sched_data} !== {1'b1, 3'(lt), d}) $display("FAIL rnd_sel: got %b/%0d/%b want 1/%0d/%b", tx_req_p, sched_lt_addr, sched_data, lt, d); else n_pass++;
        finish_slot(to);
        exp_ack = d && dec_hecgood && lt_addressed && rx_arqn && !to;
        if (exp_ack) m_seqn[lt] = ~m_seqn[lt];
        n_chk++; if ({ack_p, txaclSEQN} !== {exp_ack, m_seqn}) $display("FAIL rnd_ack: got %b/%h want %b/%h", ack_p, txaclSEQN, exp_ack, m_seqn); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_poll_rr();
    test_wrap_data();
    test_ack();
    test_flow_stop();
    test_slot_miss();
    test_enable_drop();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
